// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: per-pixel fetch stage in front of a 64x64 1-bpp sprite ROM.
// It takes the scan position and sprite placement, generates the ROM word
// address, carries the bit index and hit flag alongside the ROM read latency,
// and registers the selected pixel bit for the colour mux.
module sprite_pixel_fetch #(
  parameter int ROM_LATENCY = 2,  // 0, 1 or 2 cycles from rom_addr_o to rom_dout_i
  parameter int MSB_FIRST   = 1   // 1: pixel 0 is bit 15, 0: pixel 0 is bit 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic [9:0]  sprite_x_i,
  input  logic [9:0]  sprite_y_i,
  input  logic [5:0]  scroll_i,
  input  logic        enable_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_dout_i,
  output logic        pixel_on_o,
  output logic        in_sprite_o
);

  // The side pipeline has one register matching the address register plus
  // one per ROM register, so its last stage lines up with rom_dout_i.
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [10:0] dx, dy;
  logic        hit;
  logic        frame_start;
  logic [5:0]  scroll_d, scroll_q;
  logic [5:0]  row;
  logic [7:0]  addr_d, addr_q;
  logic [DEPTH-1:0]       hit_pipe_q;
  logic [DEPTH-1:0][3:0]  idx_pipe_q;
  logic        hit_d;
  logic [3:0]  bitidx_d;
  logic [3:0]  sel;
  logic        pixel_d;
  logic        pixel_q, in_sprite_q;

  // Stage 0: window test. The 11-bit differences have bit 10 as their sign,
  // so positions left of / above the sprite and clipped sprites never wrap.
  always_comb begin
    dx          = {1'b0, hcount_i} - {1'b0, sprite_x_i};
    dy          = {1'b0, vcount_i} - {1'b0, sprite_y_i};
    hit         = enable_i & ~dx[10] & (dx[9:6] == 4'd0)
                           & ~dy[10] & (dy[9:6] == 4'd0);
    frame_start = (hcount_i == 10'd0) && (vcount_i == 10'd0);
    // The (0,0) pixel already sees the value being loaded this cycle.
    scroll_d    = frame_start ? scroll_i : scroll_q;
    row         = dy[5:0] + scroll_d;
    // Address only moves inside the window to avoid needless ROM toggling.
    addr_d      = hit ? {row, dx[5:4]} : addr_q;
  end

  // Scroll offset latched once per frame, plus the ROM address register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scroll_q <= 6'd0;
      addr_q   <= 8'd0;
    end else begin
      scroll_q <= scroll_d;
      addr_q   <= addr_d;
    end
  end

  // Hit flag and bit index ride along with the ROM read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      hit_pipe_q[0] <= hit;
      idx_pipe_q[0] <= dx[3:0];
      for (int i = 1; i < DEPTH; i++) begin
        hit_pipe_q[i] <= hit_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

  // Bit select from the ROM word for the pixel now at the end of the pipe.
  always_comb begin
    hit_d    = hit_pipe_q[DEPTH-1];
    bitidx_d = idx_pipe_q[DEPTH-1];
    sel      = (MSB_FIRST != 0) ? (4'd15 - bitidx_d) : bitidx_d;
    pixel_d  = hit_d & rom_dout_i[sel];
  end

  // Registered outputs to the colour mux.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pixel_q     <= 1'b0;
      in_sprite_q <= 1'b0;
    end else begin
      pixel_q     <= pixel_d;
      in_sprite_q <= hit_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign pixel_on_o  = pixel_q;
  assign in_sprite_o = in_sprite_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: four instances sharing one stimulus
// (latency 2/1/0 MSB-first, latency 2 LSB-first), each with its own ROM model.
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hc, vc, sx, sy;
  logic [5:0]  scroll;
  logic        en;

  logic [7:0]  a2, a1, a0, am;
  logic [15:0] d2, d1, d0, dm;
  logic        p2, p1, p0, pm;
  logic        i2, i1, i0, im;

  logic [15:0] rom  [256];
  logic [15:0] romm [256];
  logic [15:0] r2a, r2b, r1a, rma, rmb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_pixel_fetch #(.ROM_LATENCY(2), .MSB_FIRST(1)) u2 (
    .clk_i(clk), .reset_i(reset), .hcount_i(hc), .vcount_i(vc),
    .sprite_x_i(sx), .sprite_y_i(sy), .scroll_i(scroll), .enable_i(en),
    .rom_addr_o(a2), .rom_dout_i(d2), .pixel_on_o(p2), .in_sprite_o(i2));
  sprite_pixel_fetch #(.ROM_LATENCY(1), .MSB_FIRST(1)) u1 (
    .clk_i(clk), .reset_i(reset), .hcount_i(hc), .vcount_i(vc),
    .sprite_x_i(sx), .sprite_y_i(sy), .scroll_i(scroll), .enable_i(en),
    .rom_addr_o(a1), .rom_dout_i(d1), .pixel_on_o(p1), .in_sprite_o(i1));
  sprite_pixel_fetch #(.ROM_LATENCY(0), .MSB_FIRST(1)) u0 (
    .clk_i(clk), .reset_i(reset), .hcount_i(hc), .vcount_i(vc),
    .sprite_x_i(sx), .sprite_y_i(sy), .scroll_i(scroll), .enable_i(en),
    .rom_addr_o(a0), .rom_dout_i(d0), .pixel_on_o(p0), .in_sprite_o(i0));
  sprite_pixel_fetch #(.ROM_LATENCY(2), .MSB_FIRST(0)) um (
    .clk_i(clk), .reset_i(reset), .hcount_i(hc), .vcount_i(vc),
    .sprite_x_i(sx), .sprite_y_i(sy), .scroll_i(scroll), .enable_i(en),
    .rom_addr_o(am), .rom_dout_i(dm), .pixel_on_o(pm), .in_sprite_o(im));

  // ROM models with 2, 1 and 0 cycles of read latency.
  always @(posedge clk) begin
    r2a <= rom[a2];  r2b <= r2a;
    r1a <= rom[a1];
    rma <= romm[am]; rmb <= rma;
  end
  assign d2 = r2b;
  assign d1 = r1a;
  assign d0 = rom[a0];
  assign dm = rmb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hc = 10'd500;
    vc = 10'd1000;
  endtask

  // One pixel followed by idle positions; checks address at +1 and the
  // outputs of each latency variant at its own +L (and not one cycle early).
  task automatic run_px(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic [7:0] ea, input logic ei, input logic ep,
                        input logic epm);
    hc = h; vc = v;
    tick(); idle();
    chk({tag, ".addr2"}, {8'h0, a2}, {8'h0, ea});
    chk({tag, ".addr0"}, {8'h0, a0}, {8'h0, ea});
    chk({tag, ".addrm"}, {8'h0, am}, {8'h0, ea});
    tick();
    chk({tag, ".in0"},  {15'h0, i0}, {15'h0, ei});
    chk({tag, ".pix0"}, {15'h0, p0}, {15'h0, ep});
    tick();
    chk({tag, ".in1"},  {15'h0, i1}, {15'h0, ei});
    chk({tag, ".pix1"}, {15'h0, p1}, {15'h0, ep});
    chk({tag, ".in2early"}, {15'h0, i2}, 16'h0);
    tick();
    chk({tag, ".in2"},  {15'h0, i2}, {15'h0, ei});
    chk({tag, ".pix2"}, {15'h0, p2}, {15'h0, ep});
    chk({tag, ".inm"},  {15'h0, im}, {15'h0, ei});
    chk({tag, ".pixm"}, {15'h0, pm}, {15'h0, epm});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 16'h0000;
      romm[i] = 16'h0000;
    end
    rom[8'h00]  = 16'h8001;
    rom[8'h03]  = 16'hFFFF;
    rom[8'h18]  = 16'h8000;
    romm[8'h00] = 16'h0001;

    reset = 1'b1; en = 1'b1; sx = 10'd100; sy = 10'd50; scroll = 6'd0;
    idle();
    repeat (3) tick();
    chk("rst.addr2", {8'h0, a2}, 16'h0);
    chk("rst.in2",   {15'h0, i2}, 16'h0);
    chk("rst.pix2",  {15'h0, p2}, 16'h0);
    chk("rst.in0",   {15'h0, i0}, 16'h0);
    reset = 1'b0;
    tick();

    // Basic placement and bit order.
    run_px("p100", 10'd100, 10'd50, 8'h00, 1'b1, 1'b1, 1'b1);
    run_px("p101", 10'd101, 10'd50, 8'h00, 1'b1, 1'b0, 1'b0);
    run_px("p115", 10'd115, 10'd50, 8'h00, 1'b1, 1'b1, 1'b0);
    // Word and row indexing, right edge.
    run_px("p163", 10'd163, 10'd50, 8'h03, 1'b1, 1'b1, 1'b0);
    run_px("p116r1", 10'd116, 10'd51, 8'h05, 1'b1, 1'b0, 1'b0);
    run_px("p164", 10'd164, 10'd51, 8'h05, 1'b0, 1'b0, 1'b0);
    // Disabled sprite: no output, address holds.
    en = 1'b0;
    run_px("dis", 10'd100, 10'd50, 8'h05, 1'b0, 1'b0, 1'b0);
    en = 1'b1;

    // Scroll latched at frame start, held mid-frame.
    scroll = 6'd10;
    run_px("fs10", 10'd0, 10'd0, 8'h05, 1'b0, 1'b0, 1'b0);
    run_px("scr10", 10'd100, 10'd110, 8'h18, 1'b1, 1'b1, 1'b0);
    scroll = 6'd20;
    run_px("scrhold", 10'd100, 10'd110, 8'h18, 1'b1, 1'b1, 1'b0);
    run_px("fs20", 10'd0, 10'd0, 8'h18, 1'b0, 1'b0, 1'b0);
    run_px("scr20", 10'd100, 10'd110, 8'h40, 1'b1, 1'b0, 1'b0);

    // Clipping past column 1023 (scroll_q is 20: row 0 -> 20).
    sx = 10'd1000;
    run_px("clip5", 10'd5, 10'd50, 8'h40, 1'b0, 1'b0, 1'b0);
    run_px("clip1023", 10'd1023, 10'd50, 8'h51, 1'b1, 1'b0, 1'b0);
    sx = 10'd100;

    // Reset mid-line while streaming hits at (100,50).
    hc = 10'd100; vc = 10'd50;
    repeat (5) tick();
    chk("stream.in2", {15'h0, i2}, 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.addr2", {8'h0, a2}, 16'h0);
    chk("mrst.in2",   {15'h0, i2}, 16'h0);
    chk("mrst.pix2",  {15'h0, p2}, 16'h0);
    chk("mrst.in0",   {15'h0, i0}, 16'h0);
    tick();
    // scroll_q cleared: row stays 0 rather than 20.
    chk("mrst.addr_row", {8'h0, a2}, 16'h00);
    chk("mrst.in2_1", {15'h0, i2}, 16'h0);
    chk("mrst.in0_1", {15'h0, i0}, 16'h0);
    tick();
    chk("mrst.in2_2", {15'h0, i2}, 16'h0);
    chk("mrst.in0_2", {15'h0, i0}, 16'h1);
    tick();
    chk("mrst.in2_3", {15'h0, i2}, 16'h0);
    chk("mrst.pix2_3", {15'h0, p2}, 16'h0);
    tick();
    chk("mrst.in2_4", {15'h0, i2}, 16'h1);
    chk("mrst.pix2_4", {15'h0, p2}, 16'h1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Per-pixel fetch stage that sits directly upstream of the 64x64 1-bpp sprite ROMs (256 x 16-bit words, 8-bit address). From the VGA scan position and the sprite's placement it generates the ROM word address, tracks the ROM's read latency, and selects the single bit for the current pixel. It emits a registered `pixel_on` / `in_sprite` pair to the colour mux. A per-frame latched vertical scroll offset lets the same block drive a spinning slot-machine reel.

## Interface
- `ROM_LATENCY`, default 2: clock cycles from `rom_addr` to valid `rom_dout`. Legal values are 0, 1 and 2, matching the combinational, one-register and two-register ROM variants.
- `MSB_FIRST`, default 1: if 1, pixel 0 of a word is bit 15; if 0, pixel 0 is bit 0.
- `clk` in 1: the one clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `hcount` in 10: current scan column.
- `vcount` in 10: current scan row.
- `sprite_x` in 10: sprite top-left column.
- `sprite_y` in 10: sprite top-left row.
- `scroll` in 6: vertical row offset; sampled once per frame.
- `enable` in 1: when 0, the sprite is treated as absent.
- `rom_addr` out 8: ROM word address, `{row[5:0], word[1:0]}`.
- `rom_dout` in 16: ROM data.
- `pixel_on` out 1: the sprite bit for the delayed pixel.
- `in_sprite` out 1: the delayed pixel lies inside the enabled sprite window.

## Operation
- **Window test (stage 0).**
  - dx = hcount − sprite_x and dy = vcount − sprite_y, both computed at 11 bits signed.
  - hit = enable & (0 ≤ dx < 64) & (0 ≤ dy < 64).
  - No modulo wrap: a sprite partly past column 1023 or row 1023 is clipped.
- **Scroll latch.**
  - `scroll_q` loads `scroll` on the cycle where hcount==0 and vcount==0.
  - It holds at all other times.
  - Reset sets it to 0.
- **Row.** row = (dy[5:0] + scroll_q) mod 64, using 6-bit wrap-around add.
- **Address register.**
  - When hit, `rom_addr` <= {row, dx[5:4]}.
  - When not hit, `rom_addr` holds its previous value (no toggling outside the window).
- **Side pipeline.** bitidx = dx[3:0] and hit travel through a shift pipeline of depth 1 + ROM_LATENCY, aligned with the ROM output.
- **Output register.**
  - `in_sprite` <= hit_d.
  - `pixel_on` <= hit_d & rom_dout[MSB_FIRST ? 15 − bitidx_d : bitidx_d].
  - `pixel_on` is 0 whenever `in_sprite` is 0.
- **Reset.** Clears `rom_addr`, `scroll_q`, every pipeline hit/bitidx stage, `pixel_on` and `in_sprite`.
- **Reset mid-line.** The outputs stay 0 until fresh hits propagate through the full latency; no stale pixel may emerge after reset.
- **Input changes.** `sprite_x`, `sprite_y` and `enable` may change on any cycle. Each pixel uses the values sampled in its own stage 0.

## Timing
- Latency: L = ROM_LATENCY + 2 cycles from the hcount/vcount sample to the `pixel_on`/`in_sprite` for that pixel. This is 4 for the default configuration.
- `rom_addr` is valid 1 cycle after its hcount sample.
- Throughput: one pixel per clock, no stalls.
- Reset values: `rom_addr` = 0x00, `pixel_on` = 0, `in_sprite` = 0.
  - The first post-reset output that can be 1 appears at cycle L after the first hit sample.
- Frame-start boundary: if `scroll` changes mid-frame, rows in the current frame keep the old `scroll_q`.
  - The new value applies starting from pixel (0,0) of the next frame.
  - The (0,0) pixel itself uses the newly loaded value.
- Timing alignment: the downstream colour and sync logic must delay hsync, vsync and blank by L to stay aligned.

## Test plan
- **Basic placement.** sprite_x=100, sprite_y=50, scroll=0, ROM_LATENCY=2, word 0 = 0x8001, MSB_FIRST=1. Drive hcount=100, vcount=50.
  - rom_addr=0x00 at +1.
  - in_sprite=1 and pixel_on=1 at +4.
  - At hcount=101: pixel_on=0.
  - At hcount=115: pixel_on=1.
- **Word and row indexing.**
  - vcount=50, hcount=163 → rom_addr=0x03.
  - vcount=51, hcount=116 → rom_addr=0x05.
  - hcount=164 → in_sprite=0 at +4, and rom_addr holds 0x05.
- **Scroll wrap.** scroll=10 latched at (0,0); vcount=110, hcount=100 → row (60+10) mod 64 = 6, rom_addr=0x18.
  - Change scroll to 20 mid-frame → rows stay offset by 10 until the next (0,0).
  - After that (0,0), the same pixel gives rom_addr=0x40.
- **Clipping and enable.**
  - sprite_x=1000, hcount=5 → in_sprite=0 (no wrap).
  - hcount=1023 → in_sprite=1, rom_addr word=1.
  - enable=0 → in_sprite=0 and pixel_on=0 throughout.
- **Latency variants.** Repeat the basic-placement test with ROM_LATENCY=0 and ROM_LATENCY=1 → the first pixel appears at +2 and +3 respectively.
  - MSB_FIRST=0 with word 0x0001 → pixel 0 on, pixel 15 off.
- **Reset mid-line.** Assert reset for 1 cycle while streaming hits.
  - Outputs are 0 on the next cycle, and rom_addr=0x00.
  - Outputs stay 0 for L cycles after release.
  - scroll_q=0 until the next frame start.
